// File: rtl/blink_sched_if.sv
// Request/grant bundle between requesters and the shared blink scheduler.
interface blink_sched_if #(parameter int NW = 4);
  logic [3:0]      req;
  logic [4*NW-1:0] req_cnt;
  logic            abort;
  logic [3:0]      gnt;
  logic [3:0]      led;
  logic [3:0]      done;
  logic            busy;
  logic            tick;

  modport master (output req, req_cnt, abort, input gnt, led, done, busy, tick);
  modport slave  (input req, req_cnt, abort, output gnt, led, done, busy, tick);
endinterface

// File: rtl/blink_sched.sv
// Round-robin scheduler sharing one blinker among four requesters.
// A prescaler produces a phase strobe; the owner gets N on/off phase pairs.
module blink_sched #(
  parameter int CBITS = 10,
  parameter int NW    = 4
) (
  input  logic         clk,
  input  logic         rst,
  blink_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SYNC, ON, OFF} state_t;

  state_t           state, state_nx;
  logic [CBITS-1:0] presc;
  logic             tick_q;
  logic [1:0]       ptr, ptr_nx;
  logic [1:0]       own, own_nx;
  logic [NW-1:0]    rem, rem_nx;
  logic [3:0]       gnt_q, gnt_nx;
  logic [3:0]       done_q, done_nx;
  logic [1:0]       pick;
  logic             pick_vld;
  logic [NW-1:0]    pick_cnt;

  // Free-running prescaler and registered phase strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc  <= '0;
      tick_q <= 1'b0;
    end else begin
      presc  <= presc + CBITS'(1);
      tick_q <= (presc == '0);
    end
  end

  // Round-robin pick: first active requester at or after the pointer.
  always_comb begin
    pick     = ptr;
    pick_vld = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[ptr + 2'(k)]) begin
        pick     = ptr + 2'(k);
        pick_vld = 1'b1;
      end
    end
  end

  assign pick_cnt = bus.req_cnt[NW*pick +: NW];

  // FSM state and sequence bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      own    <= '0;
      rem    <= '0;
      gnt_q  <= '0;
      done_q <= '0;
    end else begin
      state  <= state_nx;
      ptr    <= ptr_nx;
      own    <= own_nx;
      rem    <= rem_nx;
      gnt_q  <= gnt_nx;
      done_q <= done_nx;
    end
  end

  // Next-state: grant in IDLE, phase steps on tick, abort beats tick.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    own_nx   = own;
    rem_nx   = rem;
    gnt_nx   = gnt_q;
    done_nx  = '0;
    if (state == IDLE) begin
      if (pick_vld) begin
        if (pick_cnt == '0) begin
          // Zero-length request completes without ever owning the blinker.
          done_nx[pick] = 1'b1;
          ptr_nx        = pick + 2'd1;
        end else begin
          own_nx   = pick;
          rem_nx   = pick_cnt;
          gnt_nx   = 4'b0001 << pick;
          state_nx = SYNC;
        end
      end
    end else if (bus.abort) begin
      state_nx = IDLE;
      gnt_nx   = '0;
      rem_nx   = '0;
      ptr_nx   = own + 2'd1;
    end else if (tick_q) begin
      case (state)
        SYNC: state_nx = ON;
        ON:   state_nx = OFF;
        OFF: begin
          if (rem > NW'(1)) begin
            rem_nx   = rem - NW'(1);
            state_nx = ON;
          end else begin
            state_nx     = IDLE;
            gnt_nx       = '0;
            rem_nx       = '0;
            done_nx[own] = 1'b1;
            ptr_nx       = own + 2'd1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.led  = (state == ON) ? gnt_q : 4'b0000;
  assign bus.done = done_q;
  assign bus.busy = (state != IDLE);
  assign bus.tick = tick_q;

endmodule

// File: tb/tb_blink_sched.sv
// Directed plus randomized bench for blink_sched with a phase-count model.
module tb_blink_sched;
  localparam int CBITS = 3;
  localparam int NW    = 4;
  localparam int PER   = 1 << CBITS;

  logic clk = 1'b0;
  logic rst = 1'b1;

  blink_sched_if #(.NW(NW)) bus();

  blink_sched #(.CBITS(CBITS), .NW(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 = none), phase number within sequence
  // (0 = waiting for first strobe, odd = lit, even = dark), blink total.
  int         e_cyc, e_owner, e_phase, e_total, e_ptr;
  logic       e_tick;
  logic [3:0] e_done;

  int         order[$];
  logic [3:0] pg;
  int         lcnt, dcnt, gi;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] m_gnt();
    return (e_owner >= 0) ? 4'(1 << e_owner) : 4'b0000;
  endfunction

  function automatic logic [3:0] m_led();
    return (e_owner >= 0 && (e_phase % 2) == 1) ? m_gnt() : 4'b0000;
  endfunction

  task automatic model_reset();
    e_cyc = 0; e_tick = 1'b0; e_owner = -1; e_phase = 0;
    e_total = 0; e_ptr = 0; e_done = '0;
  endtask

  task automatic model_step();
    int  n, i;
    bit  found;
    if (rst) begin
      model_reset();
    end else begin
      e_done = '0;
      if (e_owner < 0) begin
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          i = (e_ptr + k) % 4;
          if (!found && bus.req[i]) begin
            found = 1'b1;
            n = int'((bus.req_cnt >> (NW * i)) & 16'hF);
            if (n == 0) begin
              e_done[i] = 1'b1;
              e_ptr = (i + 1) % 4;
            end else begin
              e_owner = i; e_total = n; e_phase = 0;
            end
          end
        end
      end else if (bus.abort) begin
        e_ptr = (e_owner + 1) % 4;
        e_owner = -1;
      end else if (e_tick) begin
        e_phase++;
        if (e_phase > 2 * e_total) begin
          e_done[e_owner] = 1'b1;
          e_ptr = (e_owner + 1) % 4;
          e_owner = -1;
        end
      end
      e_cyc++;
      e_tick = (((e_cyc - 1) % PER) == 0);
    end
  endtask

  // One clock: advance model with current inputs, clock, then compare.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("gnt",  16'(bus.gnt),  16'(m_gnt()));
    check("led",  16'(bus.led),  16'(m_led()));
    check("done", 16'(bus.done), 16'(e_done));
    check("busy", 16'(bus.busy), 16'(e_owner >= 0));
    check("tick", 16'(bus.tick), 16'(e_tick));
  endtask

  task automatic run_until_idle(input int bound);
    int n = 0;
    while (e_owner >= 0 && n < bound) begin
      cyc();
      n++;
    end
    check("idle_timeout", 16'(e_owner >= 0), 16'd0);
  endtask

  initial begin
    bus.req = '0; bus.req_cnt = '0; bus.abort = 1'b0;
    model_reset();
    repeat (2) cyc();
    rst = 1'b0;

    // Four requesters, count 1 each: grants rotate 0,1,2,3,0.
    bus.req_cnt = 16'h1111; bus.req = 4'hF; pg = '0;
    for (int n = 0; n < 300 && order.size() < 5; n++) begin
      cyc();
      if (bus.gnt != 0 && pg == 0) begin
        gi = 0;
        for (int b = 0; b < 4; b++) if (bus.gnt[b]) gi = b;
        order.push_back(gi);
      end
      pg = bus.gnt;
    end
    check("rr_count", 16'(order.size()), 16'd5);
    if (order.size() == 5) begin
      check("rr_0", 16'(order[0]), 16'd0);
      check("rr_1", 16'(order[1]), 16'd1);
      check("rr_2", 16'(order[2]), 16'd2);
      check("rr_3", 16'(order[3]), 16'd3);
      check("rr_4", 16'(order[4]), 16'd0);
    end
    bus.req = '0;
    run_until_idle(100);

    // Requester 0, two blinks: 16 lit cycles and one done pulse.
    bus.req_cnt = 16'h0002; bus.req = 4'b0001;
    cyc();
    check("gnt0", 16'(bus.gnt), 16'h1);
    bus.req = '0; bus.req_cnt = 16'h000F;
    lcnt = 0; dcnt = 0;
    for (int n = 0; n < 60; n++) begin
      cyc();
      lcnt += int'(bus.led[0]);
      dcnt += int'(bus.done[0]);
    end
    check("blink2_led_cycles", 16'(lcnt), 16'd16);
    check("blink2_done_pulses", 16'(dcnt), 16'd1);
    check("blink2_busy_end", 16'(bus.busy), 16'd0);

    // Zero count: immediate done, no grant.
    bus.req_cnt = 16'h0000; bus.req = 4'b0100;
    cyc();
    check("zero_done", 16'(bus.done), 16'h4);
    check("zero_gnt", 16'(bus.gnt), 16'h0);
    bus.req = '0;
    repeat (3) cyc();

    // Abort during second lit phase of requester 1; requester 2 waits.
    bus.req_cnt = 16'h0130; bus.req = 4'b0110;
    for (int n = 0; n < 100 && !(e_owner == 1 && e_phase == 3); n++) cyc();
    check("abort_reach", 16'(e_owner == 1 && e_phase == 3), 16'd1);
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    check("abort_led", 16'(bus.led), 16'h0);
    check("abort_gnt", 16'(bus.gnt), 16'h0);
    check("abort_done", 16'(bus.done), 16'h0);
    cyc();
    check("abort_next_gnt", 16'(bus.gnt), 16'h4);
    bus.req = '0;
    run_until_idle(100);

    // Abort coinciding with the strobe while dark.
    bus.req_cnt = 16'h0002; bus.req = 4'b0001;
    for (int n = 0; n < 100 && !(e_owner == 0 && e_phase == 2 && e_tick); n++) cyc();
    check("abort_tick_reach", 16'(e_owner == 0 && e_phase == 2 && e_tick), 16'd1);
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0; bus.req = '0;
    check("abort_tick_busy", 16'(bus.busy), 16'd0);
    lcnt = 0;
    for (int n = 0; n < 20; n++) begin
      cyc();
      lcnt += int'(bus.led[0]);
    end
    check("abort_tick_noled", 16'(lcnt), 16'd0);

    // Reset mid-lit phase clears outputs without a clock edge.
    bus.req_cnt = 16'h0003; bus.req = 4'b0001;
    for (int n = 0; n < 100 && !(e_owner == 0 && e_phase == 1); n++) cyc();
    check("rst_reach", 16'(e_owner == 0 && e_phase == 1), 16'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_led", 16'(bus.led), 16'h0);
    check("rst_gnt", 16'(bus.gnt), 16'h0);
    check("rst_busy", 16'(bus.busy), 16'd0);
    check("rst_done", 16'(bus.done), 16'h0);
    bus.req = '0;
    repeat (2) cyc();
    rst = 1'b0;
    bus.req_cnt = 16'h1001; bus.req = 4'b1001;
    cyc();
    check("rst_ptr_gnt", 16'(bus.gnt), 16'h1);
    bus.req = '0;
    run_until_idle(100);

    // Randomized traffic, count fields changing every cycle.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) bus.req = 4'($urandom_range(0, 15));
      bus.req_cnt = 16'($urandom) & 16'h3333;
      bus.abort = ($urandom_range(0, 39) == 0);
      cyc();
    end
    bus.abort = 1'b0; bus.req = '0;
    run_until_idle(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
